// File: rtl/rm_seq_pkg.sv
// Shared types and constants for the runtime-monitor symbol sequencer.
// Holds the FSM state encoding, the default widths and the symbol type.
package rm_seq_pkg;

    localparam int SEQ_SYM_W      = 8;
    localparam int SEQ_FIFO_DEPTH = 4;
    localparam int SEQ_CNT_W      = 16;
    localparam int PTR_W          = $clog2(SEQ_FIFO_DEPTH);
    localparam logic [SEQ_CNT_W-1:0] CNT_MAX = {SEQ_CNT_W{1'b1}};

    typedef logic [SEQ_SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARST  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/rm_sym_fifo.sv
// Two-write / one-read symbol FIFO with flush and in-order dual push.
// An empty FIFO forwards the first pushed symbol straight to the read side.
module rm_sym_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 push_cnt,
    input  logic [W-1:0]               wdata0,
    input  logic [W-1:0]               wdata1,
    input  logic                       pop_en,
    output logic                       pop_valid,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign pop_valid = pop_en && ((count != '0) || (push_cnt != 2'd0));
    assign pop_data  = (count != '0) ? mem[rd_ptr] : wdata0;

    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= wdata0;
        end
        if (push_cnt == 2'd2) begin
            mem[PW'(wr_ptr + PW'(1))] <= wdata1;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally; count carries the extra bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= PW'(wr_ptr + PW'(push_cnt));
            rd_ptr <= PW'(rd_ptr + PW'(pop_valid));
            count  <= count + (PW+1)'(push_cnt) - (PW+1)'(pop_valid);
        end
    end

endmodule

// File: rtl/rm_symbol_sequencer.sv
// Merges two commit ports into one in-order symbol stream for a runtime-monitor
// automaton, sequences its reset, and keeps sticky qualified-report status.
module rm_symbol_sequencer
    import rm_seq_pkg::*;
#(
    parameter int SYM_W       = SEQ_SYM_W,
    parameter int NR_PORTS    = 2,
    parameter int FIFO_DEPTH  = SEQ_FIFO_DEPTH,
    parameter int NUM_REPORTS = 4,
    parameter int RST_CYCLES  = 2,
    parameter int CNT_W       = SEQ_CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      restart_i,
    input  logic [NR_PORTS-1:0]       commit_valid_i,
    input  logic [NR_PORTS*SYM_W-1:0] commit_sym_i,
    output logic                      commit_ready_o,
    output logic                      auto_reset_o,
    output logic                      auto_run_o,
    output logic [SYM_W-1:0]          auto_sym_o,
    input  logic [NUM_REPORTS-1:0]    auto_report_i,
    output logic                      violation_o,
    output logic [NUM_REPORTS-1:0]    report_vec_o,
    output logic [CNT_W-1:0]          violation_cnt_o,
    output logic                      busy_o
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    free;
    logic [1:0]       n_valid;
    logic [1:0]       n_push;
    logic             fits;
    logic             push_ok;
    logic             restart_run;
    logic             pop_en;
    logic             pop_valid;
    logic [SYM_W-1:0] pop_data;
    logic [SYM_W-1:0] sym0;
    logic [SYM_W-1:0] sym1;
    logic [SYM_W-1:0] push_sym0;
    logic             rq_q;
    logic             rq_d;
    logic [NUM_REPORTS-1:0] qualified;

    assign sym0      = commit_sym_i[0*SYM_W +: SYM_W];
    assign sym1      = commit_sym_i[1*SYM_W +: SYM_W];
    assign n_valid   = {1'b0, commit_valid_i[0]} + {1'b0, commit_valid_i[1]};
    assign free      = CW'(FIFO_DEPTH) - fifo_count;
    assign fits      = CW'(n_valid) <= free;

    assign restart_run = (state_q == RUN) && restart_i;
    assign push_ok     = (state_q == RUN) && !restart_i && fits;
    assign n_push      = push_ok ? n_valid : 2'd0;
    // A lone port-1 commit becomes the first (and only) pushed entry.
    assign push_sym0   = commit_valid_i[0] ? sym0 : sym1;
    assign pop_en      = ((state_q == RUN) && !restart_i) || (state_q == DRAIN);

    // Outside RUN commits are dropped, so the core is never stalled.
    assign commit_ready_o = rst_ni && ((state_q != RUN) || restart_i || fits);
    assign auto_reset_o   = (state_q == IDLE) || (state_q == ARST);
    assign busy_o         = (state_q != IDLE) || (fifo_count != '0);

    rm_sym_fifo #(
        .W     (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (restart_run),
        .push_cnt  (n_push),
        .wdata0    (push_sym0),
        .wdata1    (sym1),
        .pop_en    (pop_en),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d   = ARST;
                    rst_cnt_d = RC_W'(RST_CYCLES - 1);
                end
            end
            ARST: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            RUN: begin
                if (restart_i) begin
                    state_d   = ARST;
                    rst_cnt_d = RC_W'(RST_CYCLES - 1);
                end else if (!enable_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reports lag the presented symbol by one cycle, hence the delayed run qualifier.
    assign rq_d      = ((state_q == RUN) || (state_q == DRAIN)) && !restart_run && auto_run_o;
    assign qualified = auto_report_i & {NUM_REPORTS{rq_q}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            auto_run_o      <= 1'b0;
            auto_sym_o      <= '0;
            rq_q            <= 1'b0;
            violation_o     <= 1'b0;
            report_vec_o    <= '0;
            violation_cnt_o <= '0;
        end else begin
            auto_run_o <= pop_valid;
            if (pop_valid) begin
                auto_sym_o <= pop_data;
            end
            rq_q <= rq_d;
            if (restart_run) begin
                violation_o     <= 1'b0;
                report_vec_o    <= '0;
                violation_cnt_o <= '0;
            end else if (qualified != '0) begin
                violation_o  <= 1'b1;
                report_vec_o <= report_vec_o | qualified;
                if (violation_cnt_o != {CNT_W{1'b1}}) begin
                    violation_cnt_o <= violation_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/rm_symbol_sequencer.md
Name: rm_symbol_sequencer

Overview:
- Sequences the per-instruction symbol stream from the commit stage into one single-symbol runtime-monitor automaton.
- The automaton has an 8-bit symbol input, run/reset controls, and NUM_REPORTS report outputs.
- Merges up to two committed symbols per cycle into strict program order through a small FIFO, and generates the automaton start-of-data reset sequence.
- Qualifies report outputs and keeps sticky violation status plus a counter for the CSR/debug side.

Parameters:
- SYM_W, 8, symbol width; matches the automaton symbols input.
- NR_PORTS, 2, commit ports merged; fixed at 2 for this revision.
- FIFO_DEPTH, 4, symbol buffer entries; power of two, at least 2.
- NUM_REPORTS, 4, automaton report outputs monitored.
- RST_CYCLES, 2, cycles the automaton reset is held high per (re)start; at least 1.
- CNT_W, 16, violation counter width.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- enable_i, in, 1, monitor enable from CSR.
- restart_i, in, 1, single-cycle request to restart the trace window.
- commit_valid_i, in, NR_PORTS, per-port symbol valid; port 0 is older.
- commit_sym_i, in, NR_PORTS*SYM_W, per-port symbol; port p occupies bits [p*SYM_W +: SYM_W].
- commit_ready_o, out, 1, all ports accepted this cycle.
- auto_reset_o, out, 1, automaton reset, active-high.
- auto_run_o, out, 1, automaton run.
- auto_sym_o, out, SYM_W, automaton symbols.
- auto_report_i, in, NUM_REPORTS, automaton report outputs.
- violation_o, out, 1, sticky violation flag.
- report_vec_o, out, NUM_REPORTS, sticky OR of qualified reports.
- violation_cnt_o, out, CNT_W, saturating count of cycles with any qualified report.
- busy_o, out, 1, FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM returns to IDLE and the FIFO empties.
  - auto_reset_o=1, auto_run_o=0, auto_sym_o=0.
  - violation_o=0, report_vec_o=0, violation_cnt_o=0, commit_ready_o=0, busy_o=0.
- FSM states:
  - IDLE: auto_reset_o=1; commits are not accepted; commit_ready_o=1 and symbols are dropped, so the core is never stalled. When enable_i=1, go to ARST and load rst_cnt=RST_CYCLES-1.
  - ARST: auto_reset_o=1 and auto_run_o=0. rst_cnt decrements; at 0 go to RUN. The automaton sees reset fall; its start_of_data fires on the first RUN cycle.
  - RUN: auto_reset_o=0. FIFO operation applies as below.
    - enable_i=0 goes to DRAIN.
    - restart_i=1 flushes the FIFO, clears the sticky status and counter, and goes to ARST. Commits offered in that cycle are dropped.
  - DRAIN: no new commits are accepted (commit_ready_o=1, symbols dropped). The FIFO empties one symbol per cycle; when it is empty go to IDLE. restart_i has no effect in DRAIN.
- Push (RUN only):
  - free = FIFO_DEPTH - count.
  - commit_ready_o = (free >= popcount(commit_valid_i)), where popcount counts the asserted valid bits.
  - When ready, push port 0 then port 1 in the same cycle. There are no partial accepts; the core holds both symbols until ready.
  - A pop in the same cycle does not count toward free.
- Pop:
  - One symbol per cycle while the FIFO is non-empty and state is RUN or DRAIN.
  - auto_sym_o and auto_run_o are registered: the popped symbol appears the cycle after the pop with auto_run_o=1.
  - auto_run_o=0 when nothing was popped; auto_sym_o holds its last value.
  - Symbol latency from accepted commit on an empty FIFO to auto_sym_o is 1 cycle.
- Report qualification:
  - The automaton STEs register the match, so a report for the symbol presented at cycle T is valid at T+1.
  - A 1-cycle delayed copy of auto_run_o (rq) qualifies the report: qualified = auto_report_i & {NUM_REPORTS{rq}}.
  - rq is cleared by a restart and in IDLE/ARST.
  - Any qualified bit sets violation_o and ORs into report_vec_o.
  - violation_cnt_o increments by 1 and saturates at all-ones.
  - Sticky state clears only on rst_ni or a restart.
- Boundaries:
  - Full FIFO with a dual commit: ready=0.
  - Pointer wrap uses a log2(FIFO_DEPTH)+1-bit count.
  - enable_i toggling inside ARST: completes ARST, then enters RUN, then DRAIN.

Decomposition:
- Package rm_seq_pkg holds:
  - state_e enum (IDLE, ARST, RUN, DRAIN);
  - localparams CNT_MAX and PTR_W;
  - sym_t typedef logic [SYM_W-1:0].
- One sub-module: rm_sym_fifo. It is a 2-write/1-read, FIFO_DEPTH-entry FIFO with flush, count output and an in-order dual push.

Test Plan:
1. Reset then enable_i=1 -> auto_reset_o high for exactly 2 cycles, then RUN. Single commit sym 0x1A -> auto_sym_o=0x1A with auto_run_o=1 one cycle later.
2. Dual commit {p0=0x05, p1=0x37} on an empty FIFO -> auto_sym_o shows 0x05 then 0x37 on consecutive cycles; commit_ready_o stays 1.
3. Fill the FIFO to 3 entries, offer a dual commit -> commit_ready_o=0 and no push. Next cycle (count 2 after a pop) -> accepted in order.
4. Drive auto_report_i=4'b0100 with rq=1 -> violation_o=1, report_vec_o=4'b0100, violation_cnt_o=1. Same value with rq=0 -> no change.
5. 3 symbols queued, then enable_i=0 -> all 3 drained with auto_run_o=1, then IDLE; new commits are dropped with ready=1.
6. RUN with 2 queued and violation_cnt_o=5, pulse restart_i -> FIFO empty, cnt=0, violation_o=0, auto_reset_o high for 2 cycles. Separately, preload the counter at 0xFFFF plus a report -> stays 0xFFFF.
